// File: rtl/debug_display_ctrl.sv
// Debug display: selects one of NCH monitored channels (manual or auto-scroll) and shows it on
// active-low 7-segment digits; also debounces a single-step pushbutton into a one-cycle pulse.
module debug_display_ctrl #(
  parameter int unsigned NCH           = 8,
  parameter int unsigned W             = 16,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned SCROLL_CYCLES = 50000000,
  localparam int unsigned NDIG         = W / 4,
  localparam int unsigned IW           = $clog2(NCH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NCH*W-1:0]    ch_data_i,
  input  logic [IW-1:0]       sel_i,
  input  logic                mode_i,
  input  logic                hold_i,
  input  logic                step_key_i,
  output logic [NDIG*7-1:0]   hex_o,
  output logic [IW-1:0]       ch_idx_o,
  output logic                step_pulse_o
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned SW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  logic          key_s1_q, key_s2_q;
  logic          key_db_q, key_db_d;
  logic          key_db_dly_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          step_pulse_q, step_pulse_d;
  logic          mode_q;
  logic [SW-1:0] scroll_q, scroll_d;
  logic [IW-1:0] ch_idx_q, ch_idx_d;
  logic [W-1:0]  disp_q, disp_d;

  // Debounce: count consecutive cycles the synchronized key disagrees with the debounced level.
  always_comb begin
    deb_cnt_d = '0;
    key_db_d  = key_db_q;
    if (key_s2_q != key_db_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        key_db_d = key_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Press is the 1->0 edge of the debounced level, seen one cycle after it happens.
  assign step_pulse_d = key_db_dly_q & ~key_db_q;

  always_comb begin
    ch_idx_d = ch_idx_q;
    scroll_d = '0;
    if (!mode_i) begin
      ch_idx_d = (32'(sel_i) < NCH) ? sel_i : '0;
    end else if (mode_q) begin
      // First auto cycle (mode_q low) leaves the counter cleared and the index untouched.
      if (scroll_q == SW'(SCROLL_CYCLES - 1)) begin
        ch_idx_d = (32'(ch_idx_q) == NCH - 1) ? '0 : ch_idx_q + 1'b1;
      end else begin
        scroll_d = scroll_q + 1'b1;
      end
    end
  end

  assign disp_d = hold_i ? disp_q : ch_data_i[32'(ch_idx_q) * W +: W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_s1_q     <= 1'b1;
      key_s2_q     <= 1'b1;
      key_db_q     <= 1'b1;
      key_db_dly_q <= 1'b1;
      deb_cnt_q    <= '0;
      step_pulse_q <= 1'b0;
      mode_q       <= 1'b0;
      scroll_q     <= '0;
      ch_idx_q     <= '0;
      disp_q       <= '0;
    end else begin
      key_s1_q     <= step_key_i;
      key_s2_q     <= key_s1_q;
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_q;
      deb_cnt_q    <= deb_cnt_d;
      step_pulse_q <= step_pulse_d;
      mode_q       <= mode_i;
      scroll_q     <= scroll_d;
      ch_idx_q     <= ch_idx_d;
      disp_q       <= disp_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    assign hex_o[7*k +: 7] = seg7(disp_q[4*k +: 4]);
  end

  assign ch_idx_o     = ch_idx_q;
  assign step_pulse_o = step_pulse_q;

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Directed bench for debug_display_ctrl with NCH=4, W=16, DEB_CYCLES=4, SCROLL_CYCLES=8.
module tb_debug_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ch_data;
  logic [1:0]  sel;
  logic        mode, hold, key;
  logic [27:0] hex;
  logic [1:0]  ch_idx;
  logic        pulse;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  debug_display_ctrl #(
    .NCH(4), .W(16), .DEB_CYCLES(4), .SCROLL_CYCLES(8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ch_data_i   (ch_data),
    .sel_i       (sel),
    .mode_i      (mode),
    .hold_i      (hold),
    .step_key_i  (key),
    .hex_o       (hex),
    .ch_idx_o    (ch_idx),
    .step_pulse_o(pulse)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] hexof(input logic [15:0] v);
    return {glyph(v[15:12]), glyph(v[11:8]), glyph(v[7:4]), glyph(v[3:0])};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; key = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd2;
    ch_data = {16'h6789, 16'h5A3C, 16'h0F0F, 16'h1234};
    tick(2);
    chk("rst_idx", 32'(ch_idx), 32'd0);
    chk("rst_hex", 32'(hex), 32'(28'h8102040));
    chk("rst_pulse", 32'(pulse), 32'd0);

    rst = 1'b0;
    tick();
    chk("sel_idx_1", 32'(ch_idx), 32'd2);
    chk("sel_hex_1", 32'(hex), 32'(hexof(16'h1234)));
    tick();
    chk("sel_hex_2", 32'(hex), 32'(hexof(16'h5A3C)));
    chk("sel_hex_lit", 32'(hex), 32'({7'b0010010, 7'b0001000, 7'b0110000, 7'b1000110}));

    ch_data[47:32] = 16'hC0DE;
    tick();
    chk("data_lat", 32'(hex), 32'(hexof(16'hC0DE)));

    sel = 2'd3;
    tick();
    chk("sel3_idx", 32'(ch_idx), 32'd3);
    chk("sel3_hex_old", 32'(hex), 32'(hexof(16'hC0DE)));
    tick();
    chk("sel3_hex", 32'(hex), 32'(hexof(16'h6789)));

    // Two-cycle glitch must not qualify
    key = 1'b0;
    tick(2);
    key = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("glitch_pulse", 32'(pulse), 32'd0);
    end

    key = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("press_c%0d", i), 32'(pulse), (i == 7) ? 32'd1 : 32'd0);
    end
    key = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("release_pulse", 32'(pulse), 32'd0);
    end

    sel = 2'd0;
    tick();
    chk("pre_auto_idx", 32'(ch_idx), 32'd0);
    mode = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("auto_c%0d", i), 32'(ch_idx), 32'(((i - 1) / 8) % 4));
    end
    mode = 1'b0; sel = 2'd2;
    tick();
    chk("auto_to_man", 32'(ch_idx), 32'd2);

    sel = 2'd0;
    tick(2);
    chk("hold_pre", 32'(hex), 32'(hexof(16'h1234)));
    hold = 1'b1;
    ch_data[15:0] = 16'hFFFF;
    tick(3);
    chk("hold_keep", 32'(hex), 32'(hexof(16'h1234)));
    sel = 2'd1;
    tick();
    chk("hold_idx", 32'(ch_idx), 32'd1);
    chk("hold_keep2", 32'(hex), 32'(hexof(16'h1234)));
    sel = 2'd0;
    tick();
    chk("hold_idx0", 32'(ch_idx), 32'd0);
    hold = 1'b0;
    tick();
    chk("hold_rel", 32'(hex), 32'(hexof(16'hFFFF)));

    sel = 2'd3;
    tick(2);
    chk("pre_rst_idx", 32'(ch_idx), 32'd3);
    key = 1'b0;
    tick(4);
    rst = 1'b1;
    tick();
    chk("mid_rst_idx", 32'(ch_idx), 32'd0);
    chk("mid_rst_hex", 32'(hex), 32'(hexof(16'h0000)));
    chk("mid_rst_pulse", 32'(pulse), 32'd0);
    rst = 1'b0;
    // Key still held: must be fully requalified after reset release
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("requal_c%0d", i), 32'(pulse), (i == 7) ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
